// File: rtl/pipelined_segment_adder.sv
// Segmented-carry adder/subtractor. Each pipeline stage adds one SW-bit segment,
// so no carry chain is longer than SW bits; valid/ready handshake with global stall.
module pipelined_segment_adder #(
  parameter int WIDTH = 64,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / SEGS;

  // One pipeline bank: operands still to be added, partial sum, and the carry
  // into the next segment. Bank 0 is the capture register, bank SEGS the output.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  stage_t           bank_q [SEGS+1];
  stage_t           bank_d [SEGS+1];
  logic [SW:0]      seg_sum [SEGS];
  logic             ovf_q, ovf_d;
  logic             msb_carry_in;
  logic             stall;

  assign stall    = bank_q[SEGS].valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      seg_sum[k] = {1'b0, bank_q[k].a[k*SW +: SW]}
                 + {1'b0, bank_q[k].b[k*SW +: SW]}
                 + (SW+1)'(bank_q[k].c);
    end
  end

  // Carry into the MSB is recovered from the MSB's sum bit and its two operands.
  assign msb_carry_in = bank_q[SEGS-1].a[WIDTH-1] ^ bank_q[SEGS-1].b[WIDTH-1]
                      ^ seg_sum[SEGS-1][SW-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; here the default is "hold", which is exactly the stall behaviour.
    bank_d = bank_q;
    ovf_d  = ovf_q;
    if (!stall) begin
      bank_d[0].valid = in_valid;
      bank_d[0].a     = a;
      bank_d[0].b     = sub ? ~b : b;
      bank_d[0].s     = '0;
      bank_d[0].c     = sub | cin;
      for (int k = 0; k < SEGS; k++) begin
        bank_d[k+1]                = bank_q[k];
        bank_d[k+1].s[k*SW +: SW]  = seg_sum[k][SW-1:0];
        bank_d[k+1].c              = seg_sum[k][SW];
      end
      ovf_d = msb_carry_in ^ seg_sum[SEGS-1][SW];
    end
  end

  // NOTE: the datapath is reset along with the valid bits because sum/cout/ovf
  // must read 0 during reset; the operand banks are reset for uniformity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= SEGS; k++) bank_q[k] <= '0;
      ovf_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every bank
      // samples the previous cycle's values, giving a true shift register.
      bank_q <= bank_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = bank_q[SEGS].valid;
  assign sum       = bank_q[SEGS].s;
  assign cout      = bank_q[SEGS].c;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Drives three configurations (64/4, 32/1, 32/8) from one stimulus stream and
// scores each against an arithmetic reference model with per-instance queues.
module tb_pipelined_segment_adder;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic        rdy0, ov0, c0, o0;
  logic [63:0] s0;
  logic        rdy1, ov1, c1, o1;
  logic [31:0] s1;
  logic        rdy2, ov2, c2, o2;
  logic [31:0] s2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          pops0    = 0;
  int          acc0     = 0;
  bit          lat_mode = 1'b0;
  logic [63:0] last_sum;
  logic        last_cout, last_ovf;
  exp_t        sb [3][$];
  int          pop_cyc [$];

  always #5 clk = ~clk;

  pipelined_segment_adder #(.WIDTH(64), .SEGS(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
    .sum(s0), .cout(c0), .ovf(o0));

  pipelined_segment_adder #(.WIDTH(32), .SEGS(1)) u_dut32s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .sum(s1), .cout(c1), .ovf(o1));

  pipelined_segment_adder #(.WIDTH(32), .SEGS(8)) u_dut32s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
    .sum(s2), .cout(c2), .ovf(o2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain w-bit arithmetic; overflow from operand and result signs.
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb_, input int w);
    logic [64:0] mask, am, bm, full;
    exp_t e;
    mask   = (65'd1 << w) - 65'd1;
    am     = {1'b0, av} & mask;
    bm     = (sb_ ? ~{1'b0, bv} : {1'b0, bv}) & mask;
    full   = am + bm + (sb_ ? 65'd1 : {64'd0, ci});
    e.sum  = 64'(full & mask);
    e.cout = full[w];
    e.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    e.acc  = 0;
    return e;
  endfunction

  task automatic score(input int idx, input int w, input logic ir, input logic ov,
                       input logic [63:0] s, input logic co, input logic of);
    exp_t e;
    if (in_valid && ir) begin
      e = model(a, b, cin, sub, w);
      e.acc = cyc + 1;
      sb[idx].push_back(e);
      if (idx == 0) acc0++;
    end
    if (ov && out_ready) begin
      if (sb[idx].size() == 0) begin
        check($sformatf("dut%0d_spurious_beat", idx), 64'd1, 64'd0);
      end else begin
        e = sb[idx].pop_front();
        check($sformatf("dut%0d_sum", idx), s, e.sum);
        check($sformatf("dut%0d_cout", idx), 64'(co), 64'(e.cout));
        check($sformatf("dut%0d_ovf", idx), 64'(of), 64'(e.ovf));
        if (idx == 0) begin
          pops0++;
          last_sum = s; last_cout = co; last_ovf = of;
          if (lat_mode) begin
            check("latency", 64'(cyc - e.acc), 64'd4);
            pop_cyc.push_back(cyc);
          end
        end
      end
    end
  endtask

  // Inputs are set at a falling edge; outputs are sampled 1 unit later.
  task automatic step();
    #1;
    if (rst_n) begin
      score(0, 64, rdy0, ov0, s0, c0, o0);
      score(1, 32, rdy1, ov1, {32'd0, s1}, c1, o1);
      score(2, 32, rdy2, ov2, {32'd0, s2}, c2, o2);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (14) step();
  endtask

  task automatic send_one(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, input logic sb_,
                          input logic [63:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int start, n;
    a = av; b = bv; cin = ci; sub = sb_;
    in_valid = 1'b1; out_ready = 1'b1;
    start = pops0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (pops0 == start && n < 30) begin step(); n++; end
    check({tag, "_arrived"}, 64'(pops0 != start), 64'd1);
    check({tag, "_sum"}, last_sum, exp_sum);
    check({tag, "_cout"}, 64'(last_cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(last_ovf), 64'(exp_ovf));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start;
    logic [63:0] held;

    #3;
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_sum", s0, 64'd0);
    check("rst_cout", 64'(c0), 64'd0);
    check("rst_ovf", 64'(o0), 64'd0);
    check("rst_in_ready", 64'(rdy0), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("first_edge_ready", 64'(rdy0), 64'd1);

    send_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    send_one("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send_one("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send_one("sub_cin_ignored", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send_one("add_cin", 64'd1, 64'd2, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0);
    send_one("sub_min", 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Back-to-back stream: fixed latency and consecutive output cycles.
    drain();
    lat_mode = 1'b1;
    pop_cyc.delete();
    start = pops0;
    for (int i = 0; i < 8; i++) begin
      a = 64'(i); b = 64'(i) << 48; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (pops0 - start < 8 && n < 30) begin step(); n++; end
    check("b2b_count", 64'(pops0 - start), 64'd8);
    for (int i = 1; i < pop_cyc.size(); i++)
      check($sformatf("b2b_consecutive_%0d", i), 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
    lat_mode = 1'b0;

    // Stall for 3 cycles with a valid output: ready low, output held.
    drain();
    in_valid = 1'b1;
    n = 0;
    while (!ov0 && n < 20) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
      step(); n++;
    end
    check("stall_out_valid_reached", 64'(ov0), 64'd1);
    out_ready = 1'b0;
    #1;
    held = s0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 64'(rdy0), 64'd0);
      check("stall_out_valid", 64'(ov0), 64'd1);
      check("stall_sum_held", s0, held);
      step();
    end
    drain();

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 3; i++) begin
      a = 64'(100 + i); b = 64'(i); cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid64", 64'(ov0), 64'd0);
    check("midrst_out_valid32s1", 64'(ov1), 64'd0);
    check("midrst_out_valid32s8", 64'(ov2), 64'd0);
    check("midrst_sum", s0, 64'd0);
    check("midrst_in_ready", 64'(rdy0), 64'd1);
    for (int i = 0; i < 3; i++) sb[i].delete();
    @(negedge clk);
    rst_n = 1'b1;
    drain();
    send_one("post_rst", 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);

    // Random traffic with random valid/ready on all three configurations.
    start = acc0;
    n = 0;
    while (acc0 - start < 10000 && n < 60000) begin
      int r;
      r = int'($urandom_range(0, 7));
      case (r)
        0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       a = 64'h7FFF_FFFF_FFFF_FFFF;
        2:       a = {32'h8000_0000, 32'h7FFF_FFFF};
        default: a = {$urandom, $urandom};
      endcase
      b         = ($urandom_range(0, 7) == 0) ? 64'd1 : {$urandom, $urandom};
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    check("random_beats_accepted", 64'(acc0 - start >= 10000), 64'd1);
    drain();
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d_queue_empty", i), 64'(sb[i].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_segment_adder.md
PIPELINED_SEGMENT_ADDER -- requirements
Module: pipelined_segment_adder

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 Parameter SEGS, default 4, number of carry segments and pipeline stages; WIDTH SHALL be an integer multiple of SEGS, SW = WIDTH/SEGS.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-010 sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 sum  output  WIDTH  result modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of bit WIDTH-1 (in subtract mode, 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 Stage k (k = 0..SEGS-1) SHALL add segment k of A and effective B (bits k*SW+SW-1 : k*SW) plus the carry registered by stage k-1 (stage 0 uses cin, or 1 when sub = 1).
REQ-018 Stage k SHALL carry the not-yet-added upper segments of A and effective B forward, plus the completed lower sum segments, as a skewed register pipeline; no combinational carry path SHALL span more than SW bits.
REQ-019 Latency SHALL be exactly SEGS cycles: a beat accepted on edge n appears with out_valid = 1 after edge n+SEGS when no stall occurs.
REQ-020 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-021 stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall (combinational).
REQ-022 While stall = 1, all pipeline registers, including per-stage valid bits, SHALL hold; sum, cout, ovf and out_valid SHALL remain stable.
REQ-023 Bubbles (stage valid = 0) SHALL propagate and SHALL be overwritten in place without blocking; in_ready SHALL NOT depend on in_valid.
REQ-024 A beat SHALL leave the output register on an edge where out_valid and out_ready are both 1; a new beat may load on the same edge.
REQ-025 sub, cin and all operand bits SHALL be captured at acceptance; later changes SHALL NOT affect in-flight beats.
REQ-026 ovf SHALL be computed in the final stage from that stage's MSB carry-in and carry-out; cout SHALL be that stage's carry-out.
REQ-027 SEGS = 1 SHALL yield a single registered full-width adder with latency 1.
REQ-028 Outputs for beats with out_valid = 0 are don't-care except as stated in Reset.

Reset
REQ-029 While rst_n = 0: all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 immediately, without waiting for clk.
REQ-030 in_ready SHALL be 1 during and after reset (no stall possible with out_valid = 0).
REQ-031 Reset asserted mid-operation SHALL discard every in-flight beat; no beat accepted before reset SHALL appear after reset release.
REQ-032 The first edge after rst_n rises SHALL be able to accept a beat.

Verification (WIDTH = 64, SEGS = 4)
REQ-033 a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, cin = 0, sub = 0 -> after 4 cycles sum = 0, cout = 1, ovf = 0 (carry ripples across all segments).
REQ-034 a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, sub = 0 -> sum = 0x8000_0000_0000_0000, cout = 0, ovf = 1; a = 5, b = 7, sub = 1 -> sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0, ovf = 0.
REQ-035 8 back-to-back beats a = i, b = i<<48, out_ready = 1 -> 8 consecutive out_valid cycles, in order, first 4 cycles after first acceptance.
REQ-036 Stream with out_ready low for 3 cycles while out_valid = 1 -> in_ready = 0 those cycles, output held unchanged, no beat lost or duplicated.
REQ-037 Assert rst_n = 0 asynchronously between edges with 3 beats in flight -> out_valid = 0 before next edge; after release no stale beat emerges.
REQ-038 Random 10,000 beats with random in_valid/out_ready, compare sum/cout/ovf to reference model, also at WIDTH = 32, SEGS = 1 and SEGS = 8.
